// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared constants, position map, rx state enum and decode helpers
//
// Purpose: common definitions for the serial Hamming receiver and the parallel decoder.
//   DATA_W / CODE_W / SYN_W : payload, codeword and syndrome widths
//   DATA_POS                : Hamming position (1-based) carrying payload bit d[i]
//   rx_state_e              : receiver FSM states
//   calc_syndrome           : even-parity syndrome of a 21-bit word
//   extract_data            : gather d0..d15 from their codeword positions
package hamming_pkg;

    localparam int DATA_W = 16;
    localparam int CODE_W = 21;
    localparam int SYN_W  = 5;

    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21};

    typedef enum logic [1:0] {
        RX_RECV   = 2'd0,
        RX_DECODE = 2'd1,
        RX_OUT    = 2'd2
    } rx_state_e;

    // Syndrome is the XOR of the positions of all set bits; zero for a clean word.
    function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CODE_W-1:0] cw);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int p = 0; p < CODE_W; p++) begin
            if (cw[p]) s = s ^ SYN_W'(p + 1);
        end
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] cw);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = cw[DATA_POS[i] - 1];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_serial_rx_if.sv
// rtl/hamming_serial_rx_if.sv - serial-in / word-out handshake bundle for hamming_serial_rx
//
// Purpose: groups the serial input beat and the decoded-word output port.
//   sin, sin_valid, sin_sof, sin_ready : serial codeword bit stream (LSB first)
//   data_out, corrected, uncorrectable : decoded payload and error flags
//   out_valid, out_ready               : output word handshake
//   corrected_cnt, uncorr_cnt          : saturating statistics (HAMMING_RX_STATS_EN only)
// Modports: slave = receiver side, master = link/consumer side.
interface hamming_serial_rx_if;

    logic                          sin;
    logic                          sin_valid;
    logic                          sin_sof;
    logic                          sin_ready;
    logic [hamming_pkg::DATA_W-1:0] data_out;
    logic                          out_valid;
    logic                          out_ready;
    logic                          corrected;
    logic                          uncorrectable;
`ifdef HAMMING_RX_STATS_EN
    logic [15:0]                   corrected_cnt;
    logic [15:0]                   uncorr_cnt;
`endif

    modport slave (
        input  sin, sin_valid, sin_sof, out_ready,
        output sin_ready, data_out, out_valid, corrected, uncorrectable
`ifdef HAMMING_RX_STATS_EN
        , output corrected_cnt, uncorr_cnt
`endif
    );

    modport master (
        output sin, sin_valid, sin_sof, out_ready,
        input  sin_ready, data_out, out_valid, corrected, uncorrectable
`ifdef HAMMING_RX_STATS_EN
        , input corrected_cnt, uncorr_cnt
`endif
    );

endinterface

// File: rtl/hamming_syndrome_fix.sv
// rtl/hamming_syndrome_fix.sv - combinational syndrome check and single-bit correction
//
// Purpose: decode one 21-bit codeword.
//   code_i          : received codeword, bit i = Hamming position i+1
//   data_o          : corrected 16-bit payload
//   corrected_o     : syndrome 1..21, that position was flipped (parity positions included)
//   uncorrectable_o : syndrome 22..31, points outside the codeword, word left as received
module hamming_syndrome_fix
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [DATA_W-1:0] data_o,
    output logic              corrected_o,
    output logic              uncorrectable_o
);

    logic [SYN_W-1:0]  syn;
    logic [CODE_W-1:0] fixed;

    always_comb begin
        syn             = calc_syndrome(code_i);
        fixed           = code_i;
        corrected_o     = 1'b0;
        uncorrectable_o = 1'b0;
        if (syn > SYN_W'(CODE_W)) begin
            uncorrectable_o = 1'b1;
        end else if (syn != '0) begin
            corrected_o = 1'b1;
            for (int p = 0; p < CODE_W; p++) begin
                if (syn == SYN_W'(p + 1)) fixed[p] = ~code_i[p];
            end
        end
        data_o = extract_data(fixed);
    end

endmodule

// File: rtl/hamming_serial_rx.sv
// rtl/hamming_serial_rx.sv - bit-serial Hamming(21,16) receiver with single-error correction
//
// Purpose: shift in a 21-bit codeword LSB first, decode it in one cycle and hold the
// payload on a valid/ready port. All outputs are registered.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset, drops any frame or pending word
//   rx    : hamming_serial_rx_if.slave (serial input, decoded output, optional counters)
// Optional feature: define HAMMING_RX_STATS_EN to add the saturating corrected_cnt and
// uncorr_cnt statistics.
module hamming_serial_rx
    import hamming_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    hamming_serial_rx_if.slave  rx
);

    rx_state_e         state_q;
    logic [4:0]        bitcnt_q;
    logic [CODE_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q;
    logic              out_valid_q;
    logic              sin_ready_q;
    logic              corrected_q;
    logic              uncorr_q;

    logic [DATA_W-1:0] fix_data_d;
    logic              fix_corr_d;
    logic              fix_uncorr_d;
    logic [4:0]        slot_d;

`ifdef HAMMING_RX_STATS_EN
    logic [15:0]       corr_cnt_q;
    logic [15:0]       uncorr_cnt_q;
`endif

    hamming_syndrome_fix u_fix (
        .code_i          (shreg_q),
        .data_o          (fix_data_d),
        .corrected_o     (fix_corr_d),
        .uncorrectable_o (fix_uncorr_d)
    );

    // A start-of-frame bit always lands in slot 0; stale upper bits of an abandoned
    // frame are overwritten before the next decode, so they need no clearing.
    always_comb begin
        shreg_d = shreg_q;
        slot_d  = rx.sin_sof ? 5'd0 : bitcnt_q;
        for (int i = 0; i < CODE_W; i++) begin
            if (slot_d == 5'(i)) shreg_d[i] = rx.sin;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RX_RECV;
            bitcnt_q     <= '0;
            shreg_q      <= '0;
            data_q       <= '0;
            out_valid_q  <= 1'b0;
            sin_ready_q  <= 1'b1;
            corrected_q  <= 1'b0;
            uncorr_q     <= 1'b0;
`ifdef HAMMING_RX_STATS_EN
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                RX_RECV: begin
                    if (rx.sin_valid) begin
                        shreg_q <= shreg_d;
                        if (rx.sin_sof) begin
                            bitcnt_q <= 5'd1;
                        end else if (bitcnt_q == 5'(CODE_W - 1)) begin
                            bitcnt_q    <= '0;
                            sin_ready_q <= 1'b0;
                            state_q     <= RX_DECODE;
                        end else begin
                            bitcnt_q <= bitcnt_q + 5'd1;
                        end
                    end
                end
                RX_DECODE: begin
                    data_q      <= fix_data_d;
                    corrected_q <= fix_corr_d;
                    uncorr_q    <= fix_uncorr_d;
                    out_valid_q <= 1'b1;
                    state_q     <= RX_OUT;
`ifdef HAMMING_RX_STATS_EN
                    if (fix_corr_d && corr_cnt_q != 16'hFFFF) corr_cnt_q <= corr_cnt_q + 16'd1;
                    if (fix_uncorr_d && uncorr_cnt_q != 16'hFFFF) uncorr_cnt_q <= uncorr_cnt_q + 16'd1;
`endif
                end
                RX_OUT: begin
                    if (rx.out_ready) begin
                        out_valid_q <= 1'b0;
                        sin_ready_q <= 1'b1;
                        bitcnt_q    <= '0;
                        state_q     <= RX_RECV;
                    end
                end
                default: begin
                    state_q     <= RX_RECV;
                    sin_ready_q <= 1'b1;
                    out_valid_q <= 1'b0;
                    bitcnt_q    <= '0;
                end
            endcase
        end
    end

    assign rx.sin_ready     = sin_ready_q;
    assign rx.data_out      = data_q;
    assign rx.out_valid     = out_valid_q;
    assign rx.corrected     = corrected_q;
    assign rx.uncorrectable = uncorr_q;
`ifdef HAMMING_RX_STATS_EN
    assign rx.corrected_cnt = corr_cnt_q;
    assign rx.uncorr_cnt    = uncorr_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_serial_rx.sv
// tb/tb_hamming_serial_rx.sv - self-checking bench for hamming_serial_rx
module tb_hamming_serial_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hamming_serial_rx_if bus ();

    hamming_serial_rx dut (
        .clk_i (clk),
        .rst_i (rst),
        .rx    (bus.slave)
    );

    int n_total = 0;
    int n_pass  = 0;
`ifdef HAMMING_RX_STATS_EN
    int exp_ccnt = 0;
    int exp_ucnt = 0;
`endif

    typedef struct {
        logic [20:0] cw;
        logic [15:0] exp_data;
        bit          exp_corr;
        bit          exp_unc;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Encoder from the code rules: data in non-power-of-two positions, then each parity
    // position 2^k makes the XOR over all positions with bit k set even.
    function automatic logic [20:0] model_encode(input logic [15:0] d);
        logic [20:0] cw;
        int j;
        bit par;
        cw = '0;
        j = 0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            par = 1'b0;
            for (int p = 1; p <= 21; p++) if (((p >> k) & 1) == 1) par ^= cw[p-1];
            cw[(1 << k) - 1] = par;
        end
        return cw;
    endfunction

    function automatic void model_decode(input logic [20:0] cw_in, output logic [15:0] d,
                                         output bit c, output bit u);
        logic [20:0] cw;
        int s;
        int j;
        cw = cw_in;
        s = 0;
        for (int p = 1; p <= 21; p++) if (cw[p-1]) s = s ^ p;
        c = 1'b0;
        u = 1'b0;
        if (s > 21) u = 1'b1;
        else if (s != 0) begin
            cw[s-1] = ~cw[s-1];
            c = 1'b1;
        end
        d = '0;
        j = 0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = cw[p-1];
                j++;
            end
        end
    endfunction

    task automatic send_bits(input logic [20:0] cw, input int nbits, input bit sof, input bit gaps);
        for (int i = 0; i < nbits; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.sin_valid = 1'b0;
                bus.sin_sof   = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            bus.sin       = cw[i];
            bus.sin_valid = 1'b1;
            bus.sin_sof   = sof && (i == 0);
            @(negedge clk);
        end
        bus.sin_valid = 1'b0;
        bus.sin_sof   = 1'b0;
    endtask

    // Called at the negedge right after the last bit was accepted (the DECODE cycle).
    task automatic expect_word(input string tag, input logic [15:0] ed, input bit ec,
                               input bit eu, input int stall);
        check({tag, "_decode_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_decode_ready"}, 32'(bus.sin_ready), 32'd0);
        @(negedge clk);
        check({tag, "_valid_n2"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.data_out), 32'(ed));
        check({tag, "_corr"}, 32'(bus.corrected), 32'(ec));
        check({tag, "_unc"}, 32'(bus.uncorrectable), 32'(eu));
`ifdef HAMMING_RX_STATS_EN
        if (ec) exp_ccnt = (exp_ccnt < 16'hFFFF) ? exp_ccnt + 1 : exp_ccnt;
        if (eu) exp_ucnt = (exp_ucnt < 16'hFFFF) ? exp_ucnt + 1 : exp_ucnt;
        check({tag, "_ccnt"}, 32'(bus.corrected_cnt), 32'(exp_ccnt));
        check({tag, "_ucnt"}, 32'(bus.uncorr_cnt), 32'(exp_ucnt));
`endif
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_stall_data"}, 32'(bus.data_out), 32'(ed));
            check({tag, "_stall_ready"}, 32'(bus.sin_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_post_ready"}, 32'(bus.sin_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] d;
        logic [20:0] cw;
        logic [15:0] md;
        bit          mc;
        bit          mu;
        int          nerr;
        int          pos0;
        int          pos1;
        int          seen;

        vecs[0] = '{21'h000007, 16'h0001, 1'b0, 1'b0};
        vecs[1] = '{21'h000010, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{21'h008000, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{21'h008080, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{21'h1FFFFE, 16'hFFFF, 1'b0, 1'b0};
        vecs[5] = '{21'h1FFFFF, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{21'h100000, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{21'h008020, 16'h0004, 1'b0, 1'b1};

        bus.sin       = 1'b0;
        bus.sin_valid = 1'b0;
        bus.sin_sof   = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_valid", 32'(bus.out_valid), 32'd0);
        check("reset_data", 32'(bus.data_out), 32'd0);
        check("reset_ready", 32'(bus.sin_ready), 32'd1);
        check("reset_corr", 32'(bus.corrected), 32'd0);
        check("reset_unc", 32'(bus.uncorrectable), 32'd0);
`ifdef HAMMING_RX_STATS_EN
        check("reset_ccnt", 32'(bus.corrected_cnt), 32'd0);
        check("reset_ucnt", 32'(bus.uncorr_cnt), 32'd0);
`endif

        for (int v = 0; v < 8; v++) begin
            send_bits(vecs[v].cw, 21, (v % 2) == 0, 1'b0);
            expect_word($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_corr,
                        vecs[v].exp_unc, v % 3);
        end

        // Resync: abandoned partial frame must produce no output.
        send_bits(21'h1FFFFF, 10, 1'b1, 1'b0);
        send_bits(21'h000007, 21, 1'b1, 1'b0);
        expect_word("resync", 16'h0001, 1'b0, 1'b0, 0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("resync_single_output", 32'(seen), 32'd0);

        // Randomised frames with 0, 1 or 2 bit errors against the model.
        for (int f = 0; f < 30; f++) begin
            d    = 16'($urandom);
            cw   = model_encode(d);
            nerr = $urandom_range(0, 2);
            pos0 = $urandom_range(0, 20);
            pos1 = (pos0 + $urandom_range(1, 20)) % 21;
            if (nerr >= 1) cw[pos0] = ~cw[pos0];
            if (nerr == 2) cw[pos1] = ~cw[pos1];
            model_decode(cw, md, mc, mu);
            if (nerr < 2) check($sformatf("rnd%0d_model_data", f), 32'(md), 32'(d));
            send_bits(cw, 21, $urandom_range(0, 1) == 1, 1'b1);
            expect_word($sformatf("rnd%0d", f), md, mc, mu, $urandom_range(0, 2));
        end

        // Hold in OUT then reset mid-OUT.
        send_bits(21'h000007, 21, 1'b1, 1'b0);
        @(negedge clk);
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d_ready", i), 32'(bus.sin_ready), 32'd0);
            check($sformatf("hold%0d_data", i), 32'(bus.data_out), 32'h0001);
            check($sformatf("hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_ready", 32'(bus.sin_ready), 32'd1);
        check("rst_out_data", 32'(bus.data_out), 32'd0);
`ifdef HAMMING_RX_STATS_EN
        exp_ccnt = 0;
        exp_ucnt = 0;
        check("rst_ccnt", 32'(bus.corrected_cnt), 32'd0);
        check("rst_ucnt", 32'(bus.uncorr_cnt), 32'd0);
`endif

        // Back-to-back after reset with out_ready already high before out_valid.
        send_bits(21'h000010, 21, 1'b1, 1'b0);
        check("early_rdy_decode_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("early_rdy_valid", 32'(bus.out_valid), 32'd1);
        check("early_rdy_corr", 32'(bus.corrected), 32'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("early_rdy_done", 32'(bus.out_valid), 32'd0);
        check("early_rdy_ready", 32'(bus.sin_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hamming_serial_rx.md
# hamming_serial_rx

Bit-serial receiver and decoder for the 21-bit Hamming codewords that carry 16-bit data. It sits at the far end of a serial link. It shifts in one codeword bit per accepted beat, computes the 5-bit syndrome, corrects any single-bit error, and presents the 16-bit payload on a valid/ready output port. It is the serial counterpart of the team's parallel coder, for links where codewords cross a 1-bit channel.

## Interface
- No parameters. Widths are fixed at a 16-bit payload and a 21-bit codeword.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sin` input 1: serial codeword bit.
- `sin_valid` input 1: `sin` is valid this cycle.
- `sin_sof` input 1: qualified by `sin_valid`; marks the current bit as codeword bit 0.
- `sin_ready` output 1: receiver accepts a bit this cycle.
- `data_out` output 16: decoded and corrected payload.
- `out_valid` output 1: `data_out` and the flags are valid.
- `out_ready` input 1: downstream accepts the word.
- `corrected` output 1: a single-bit error was corrected in this word.
- `uncorrectable` output 1: the syndrome points outside the codeword.
- `corrected_cnt` output 16 (macro only): count of corrected words.
- `uncorr_cnt` output 16 (macro only): count of uncorrectable words.

## Operation
- Codeword bit i corresponds to Hamming position i+1.
- Parity bits sit at positions 1, 2, 4, 8, 16.
- Data bits d0..d15 fill positions 3, 5, 6, 7, 9–15, 17–21 in ascending order.
- Parity is even: syndrome bit k is the XOR of all received bits whose position has bit k set.
- Bits are sent LSB first, so codeword bit 0 arrives first.
- A bit is accepted when `sin_valid && sin_ready`.
- FSM states:
  - RECV: `sin_ready`=1. Shift the accepted bit into slot `bitcnt`. `bitcnt` counts 0..20. On accepting bit 20, go to DECODE.
  - DECODE: one cycle, `sin_ready`=0. Compute syndrome S.
    - S=0: no change, both flags 0.
    - 1≤S≤21: flip position S, `corrected`=1. This covers parity-only positions.
    - S>21: no flip, `uncorrectable`=1.
    - Register payload and flags, then go to OUT.
  - OUT: `out_valid`=1, `sin_ready`=0. Hold `data_out` and flags stable until `out_ready`. On handshake, go to RECV with `bitcnt`=0.
- Resync: an accepted bit with `sin_sof`=1 in RECV is written as bit 0 and sets `bitcnt` to 1, whatever `bitcnt` was. The partial frame is discarded without reporting.
- `sin_sof` is ignored outside RECV, since no bit is accepted there.
- Double errors may alias to a valid position and be miscorrected. This is inherent to the code and is not flagged.
- Reset values:
  - State RECV, `bitcnt`=0, shift register 0.
  - `data_out`=0, `out_valid`=0, `corrected`=0, `uncorrectable`=0.
  - `sin_ready`=1 from the first cycle after reset.
  - Counters 0.
- Reset has priority over every other event, including mid-frame and during OUT. Any pending word is dropped.

## Timing
- Bit 20 accepted in cycle N → DECODE in N+1 → `out_valid` high in N+2.
- Minimum frame period is 23 cycles: 21 RECV, 1 DECODE, 1 OUT with `out_ready` already high.
- `sin_valid` gaps stall RECV with no state change.
- `out_ready` may be high before `out_valid`. The transfer then occurs in the first OUT cycle.
- The earliest next bit acceptance is the cycle after the OUT handshake.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `HAMMING_RX_STATS_EN` defined:
  - `corrected_cnt` and `uncorr_cnt` exist.
  - Each increments by 1 in the DECODE cycle that sets the matching flag.
  - Both saturate at 0xFFFF and clear only on `rst`.
- Undefined: both ports and their counter logic are absent. All other behaviour is identical.

## Structure
- Shared package `hamming_pkg`:
  - Constants `DATA_W`=16, `CODE_W`=21, `SYN_W`=5.
  - The data-position map.
  - The rx FSM state enum.
  - Syndrome and extract functions, reusable by the parallel decoder.
- One natural sub-module, `hamming_syndrome_fix`. It is combinational: 21-bit word in, corrected 16-bit data plus both flags out. The FSM, shifter and counters stay in the top.

## Test plan
- Send codeword 21'h000007, no errors → `data_out`=0x0001, flags 0, `out_valid` at cycle N+2.
- Send all-zero codeword with position 5 flipped (21'h000010) → `data_out`=0x0000, `corrected`=1.
- Send all-zero codeword with position 16 flipped (21'h008000) → `data_out`=0x0000, `corrected`=1 (parity-only fix).
- Send positions 8 and 16 set (21'h008080, S=24) → `uncorrectable`=1, `data_out`=0x0000; with the macro, `uncorr_cnt`=1.
- Send 10 bits of 21'h1FFFFF, then `sin_sof` with the full 21'h000007 → exactly one output, 0x0001.
- Hold `out_ready`=0 for 5 cycles in OUT → `sin_ready`=0 and `data_out` stable throughout. Assert `rst` mid-OUT → next cycle `out_valid`=0, `sin_ready`=1.
